// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_adder_pkg;

  localparam int SA_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, purely combinational.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder/subtractor: one fulladder stepped LSB first, one bit per clock,
// with a start/busy/done handshake and held result registers.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int N = SA_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  sa_state_e      state_q;
  logic [N-1:0]   a_sr_q;
  logic [N-1:0]   b_sr_q;
  logic [N-1:0]   sum_sr_q;
  logic [N-1:0]   sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic           carry_q;
  logic           msb_cin_q;
  logic           cout_q;
  logic           busy_q;
  logic           done_q;
  logic           fa_sum;
  logic           fa_carry;

  fulladder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // NOTE: non-blocking assignments make every right-hand side read the pre-edge value,
  // which is exactly what the final step needs when it captures the old carry into msb_cin_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
            a_sr_q   <= a;
            b_sr_q   <= b ^ {N{sub}};
            carry_q  <= sub;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_sr_q <= {fa_sum, sum_sr_q[N-1:1]};
          carry_q  <= fa_carry;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            msb_cin_q <= carry_q;
            sum_q     <= {fa_sum, sum_sr_q[N-1:1]};
            cout_q    <= fa_carry;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  // Overflow is carry into MSB xor carry out of MSB, both captured on the final step.
  assign ovf  = cout_q ^ msb_cin_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: N=8 directed/back-to-back/abort tests and an N=2 sweep.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res8_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       sub8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       sub2 = 1'b0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  res8_t sb_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  logic  prev_done8 = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  function automatic res8_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bb;
    logic [8:0] full;
    res8_t      r;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {8'd0, s};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (a[7] == bb[7]) && (r.sum[7] != a[7]);
    return r;
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] a, input logic [1:0] b, input logic s);
    logic [1:0] bb;
    logic [2:0] full;
    logic       o;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {2'd0, s};
    o    = (a[1] == bb[1]) && (full[1] != a[1]);
    return {full[1:0], full[2], o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops the scoreboard on every done pulse of the N=8 instance.
  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      res8_t exp;
      n_cmp++;
      if (prev_done8) begin
        n_mis++;
        $display("FAIL done_pulse_width: done high on two consecutive cycles, expected single pulse");
      end
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding, expected done=0");
      end else begin
        exp = sb_q.pop_front();
        if ({sum8, cout8, ovf8} !== exp) begin
          n_mis++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   sum8, cout8, ovf8, exp.sum, exp.cout, exp.ovf);
        end
      end
    end
    prev_done8 = (done8 === 1'b1) && !rst;
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_mis++;
      $display("FAIL reset_state8: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    n_cmp++;
    if ({busy2, done2, sum2, cout2, ovf2} !== 6'h00) begin
      n_mis++;
      $display("FAIL reset_state2: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy2, done2, sum2, cout2, ovf2);
    end
    rst = 1'b0;
    tick();
  endtask

  // One operation from IDLE: expected result is queued at the accept edge.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    res8_t      exp;
    logic [7:0] hold_sum;
    int         k;
    exp.sum  = exp_sum;
    exp.cout = exp_cout;
    exp.ovf  = exp_ovf;
    hold_sum = sum8;
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    tick();
    sb_q.push_back(exp);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_mis++;
      $display("FAIL busy_after_accept: got %b, expected 1", busy8);
    end
    k = 0;
    while (done8 !== 1'b1 && k < 20) begin
      tick();
      k++;
      if (k == 4) begin
        n_cmp++;
        if (sum8 !== hold_sum) begin
          n_mis++;
          $display("FAIL sum_stable_in_run: got %h, expected %h", sum8, hold_sum);
        end
      end
    end
    n_cmp++;
    if (k != 8) begin
      n_mis++;
      $display("FAIL done_latency: done seen %0d edges after accept, expected 8 (sampled at edge 9)", k);
    end
    tick();
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_after_done: got done=%b busy=%b, expected 0 0", done8, busy8);
    end
  endtask

  task automatic test_add();
    run_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    run_op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int    last_acc = -1;
    int    cyc = 0;
    int    n_acc = 0;
    int    k;
    logic  prev_busy;
    res8_t exp;
    prev_busy = busy8;
    start8 = 1'b1;
    while (n_acc < 4 && cyc < 60) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      exp = model8(a8, b8, sub8);
      tick();
      cyc++;
      if (!prev_busy && busy8 === 1'b1) begin
        sb_q.push_back(exp);
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 10) begin
            n_mis++;
            $display("FAIL accept_spacing: got %0d cycles, expected 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      prev_busy = busy8;
    end
    start8 = 1'b0;
    n_cmp++;
    if (n_acc != 4) begin
      n_mis++;
      $display("FAIL accept_count: got %0d accepts, expected 4", n_acc);
    end
    k = 0;
    while (busy8 !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy8 !== 1'b0) begin
      n_mis++;
      $display("FAIL drain_timeout: busy=%b after 20 cycles, expected 0", busy8);
    end
  endtask

  task automatic test_abort();
    logic saw_done = 1'b0;
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_mis++;
      $display("FAIL abort_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_no_done: got done pulse after abort, expected none");
    end
    run_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
  endtask

  task automatic test_sweep_n2();
    logic [3:0] exp;
    int         k;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          a2 = 2'(x); b2 = 2'(y); sub2 = 1'(s); start2 = 1'b1;
          exp = model2(a2, b2, sub2);
          tick();
          start2 = 1'b0;
          k = 0;
          while (done2 !== 1'b1 && k < 10) begin
            tick();
            k++;
          end
          n_cmp++;
          if (k >= 10 || {sum2, cout2, ovf2} !== exp) begin
            n_mis++;
            $display("FAIL sweep_n2 a=%0d b=%0d sub=%0d: got %b, expected %b (sum,cout,ovf)",
                     x, y, s, {sum2, cout2, ovf2}, exp);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_abort();
    test_sweep_n2();
    repeat (3) tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d outstanding results, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
